// File: rtl/mxu_mac_pe.sv
// Systolic MAC processing element: psum_out = psum_in + data_in * weight, with a shadow/active
// weight pair, configurable result and forwarding latency, and saturating or wrapping accumulation.
module mxu_mac_pe #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ACC_W    = 20,
    parameter int unsigned LAT      = 2,
    parameter int unsigned FWD_LAT  = 1,
    parameter int unsigned SIGNED   = 1,
    parameter int unsigned SATURATE = 1
) (
    input  logic              clk,
    input  logic              sclr,
    input  logic              ce,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic [DATA_W-1:0] w_in,
    input  logic              w_load,
    input  logic              w_swap,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] w_out,
    output logic [ACC_W-1:0]  psum_out,
    output logic              valid_out,
    output logic              ovf
);

    localparam int unsigned PW  = 2 * DATA_W;
    localparam int unsigned SW  = ACC_W + 1;
    localparam bit          SGN = (SIGNED != 0);
    localparam bit          SAT = (SATURATE != 0);

    if (ACC_W < PW) begin : g_bad_acc_w
        $error("mxu_mac_pe: ACC_W must be at least 2*DATA_W");
    end
    if (LAT < 2 || LAT > 4) begin : g_bad_lat
        $error("mxu_mac_pe: LAT must be in 2..4");
    end
    if (FWD_LAT < 1 || FWD_LAT > 4) begin : g_bad_fwd_lat
        $error("mxu_mac_pe: FWD_LAT must be in 1..4");
    end

    // Weights are deliberately not gated by ce so the weight chain can shift during a stall.
    logic [DATA_W-1:0] shadow_q, active_q;

    always_ff @(posedge clk) begin
        if (sclr) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            if (w_swap) active_q <= shadow_q;
            if (w_load) shadow_q <= w_in;
        end
    end

    assign w_out = shadow_q;

    // Stage 1: full-width product plus the matching psum_in.
    logic [PW-1:0]    data_ext, w_ext, prod_d, prod_q;
    logic [ACC_W-1:0] psum1_q;
    logic [LAT-1:0]   vld_q;

    assign data_ext = {{DATA_W{SGN & data_in[DATA_W-1]}}, data_in};
    assign w_ext    = {{DATA_W{SGN & active_q[DATA_W-1]}}, active_q};
    assign prod_d   = data_ext * w_ext;

    always_ff @(posedge clk) begin
        if (sclr) begin
            prod_q  <= '0;
            psum1_q <= '0;
            vld_q   <= '0;
        end else if (ce) begin
            prod_q  <= prod_d;
            psum1_q <= psum_in;
            vld_q   <= {vld_q[LAT-2:0], valid_in};
        end
    end

    // Stage 2: one guard bit above ACC_W is enough to see every overflow.
    logic [SW-1:0]    prod_x, psum_x, sum;
    logic [ACC_W-1:0] res_d;
    logic             ovf_d;

    assign prod_x = {{(SW - PW){SGN & prod_q[PW-1]}}, prod_q};
    assign psum_x = {SGN & psum1_q[ACC_W-1], psum1_q};
    assign sum    = prod_x + psum_x;

    always_comb begin
        ovf_d = SGN ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
        res_d = sum[ACC_W-1:0];
        if (ovf_d && SAT) begin
            if (SGN) begin
                res_d = sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
            end else begin
                res_d = '1;
            end
        end
    end

    // Extra latency sits between the adder and the output register; stages load only on valid
    // so the output holds its last result through bubbles.
    logic [ACC_W-1:0] res_last;
    logic             ovr_last;

    if (LAT > 2) begin : g_dly
        logic [ACC_W-1:0] dres_q [LAT-2];
        logic [LAT-3:0]   dovr_q;

        always_ff @(posedge clk) begin
            if (sclr) begin
                for (int i = 0; i < int'(LAT) - 2; i++) dres_q[i] <= '0;
                dovr_q <= '0;
            end else if (ce) begin
                if (vld_q[0]) begin
                    dres_q[0] <= res_d;
                    dovr_q[0] <= ovf_d;
                end
                for (int i = 1; i < int'(LAT) - 2; i++) begin
                    if (vld_q[i]) begin
                        dres_q[i] <= dres_q[i-1];
                        dovr_q[i] <= dovr_q[i-1];
                    end
                end
            end
        end

        assign res_last = dres_q[LAT-3];
        assign ovr_last = dovr_q[LAT-3];
    end else begin : g_no_dly
        assign res_last = res_d;
        assign ovr_last = ovf_d;
    end

    logic [ACC_W-1:0] psum_q;
    logic             ovf_q;
    logic             out_load;

    assign out_load = ce & vld_q[LAT-2];

    always_ff @(posedge clk) begin
        if (sclr) begin
            psum_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (out_load) psum_q <= res_last;
            if (out_load && ovr_last) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign psum_out  = psum_q;
    assign valid_out = vld_q[LAT-1];
    assign ovf       = ovf_q;

    // East forwarding: plain ce-gated shift, independent of valid_in.
    logic [DATA_W-1:0] fwd_q [FWD_LAT];

    always_ff @(posedge clk) begin
        if (sclr) begin
            for (int i = 0; i < int'(FWD_LAT); i++) fwd_q[i] <= '0;
        end else if (ce) begin
            fwd_q[0] <= data_in;
            for (int i = 1; i < int'(FWD_LAT); i++) fwd_q[i] <= fwd_q[i-1];
        end
    end

    assign data_out = fwd_q[FWD_LAT-1];

endmodule

// File: tb/tb_mxu_mac_pe.sv
// Randomised bench for mxu_mac_pe: three parameterisations share stimulus and are checked every
// cycle against an arithmetic model, with hand-computed pins for the directed scenarios.
module tb_mxu_mac_pe;

    logic        clk = 1'b0;
    logic        sclr, ce, valid_in, w_load, w_swap, ovf_clr;
    logic [7:0]  data_in, w_in;
    logic [19:0] psum_in;

    logic [19:0] psum_o  [3];
    logic        valid_o [3];
    logic        ovf_o   [3];
    logic [7:0]  data_o  [3];
    logic [7:0]  wout_o  [3];

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    always #5 clk = ~clk;

    mxu_mac_pe u_dut0 (
        .clk(clk), .sclr(sclr), .ce(ce), .data_in(data_in), .valid_in(valid_in),
        .psum_in(psum_in), .w_in(w_in), .w_load(w_load), .w_swap(w_swap), .ovf_clr(ovf_clr),
        .data_out(data_o[0]), .w_out(wout_o[0]), .psum_out(psum_o[0]), .valid_out(valid_o[0]),
        .ovf(ovf_o[0])
    );

    mxu_mac_pe #(.LAT(3), .FWD_LAT(2), .SATURATE(0)) u_dut1 (
        .clk(clk), .sclr(sclr), .ce(ce), .data_in(data_in), .valid_in(valid_in),
        .psum_in(psum_in), .w_in(w_in), .w_load(w_load), .w_swap(w_swap), .ovf_clr(ovf_clr),
        .data_out(data_o[1]), .w_out(wout_o[1]), .psum_out(psum_o[1]), .valid_out(valid_o[1]),
        .ovf(ovf_o[1])
    );

    mxu_mac_pe #(.LAT(4), .FWD_LAT(4), .SIGNED(0)) u_dut2 (
        .clk(clk), .sclr(sclr), .ce(ce), .data_in(data_in), .valid_in(valid_in),
        .psum_in(psum_in), .w_in(w_in), .w_load(w_load), .w_swap(w_swap), .ovf_clr(ovf_clr),
        .data_out(data_o[2]), .w_out(wout_o[2]), .psum_out(psum_o[2]), .valid_out(valid_o[2]),
        .ovf(ovf_o[2])
    );

    function automatic int lat(input int k);
        case (k)
            0:       return 2;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int fwd(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit sgn(input int k);
        return k != 2;
    endfunction

    function automatic bit sat(input int k);
        return k != 1;
    endfunction

    // Plain integer arithmetic: psum + data*weight, then range-check against the ACC_W range.
    task automatic calc(input bit sg, input bit st, input logic [7:0] d, input logic [7:0] w,
                        input logic [19:0] p, output logic [19:0] r, output bit o);
        longint a, b, c, s, lo, hi;
        if (sg) begin
            a  = longint'($signed(d));
            b  = longint'($signed(w));
            c  = longint'($signed(p));
            lo = -524288;
            hi = 524287;
        end else begin
            a  = longint'(d);
            b  = longint'(w);
            c  = longint'(p);
            lo = 0;
            hi = 1048575;
        end
        s = c + a * b;
        o = (s < lo) || (s > hi);
        if (o && st) s = (s < lo) ? lo : hi;
        r = s[19:0];
    endtask

    // Model: results are scheduled by enabled-cycle count into small ring buffers.
    int          cnt = 0;
    logic [7:0]  m_sh = '0, m_ac = '0;
    logic [19:0] rv [3][8];
    bit          rp [3][8];
    bit          ro [3][8];
    logic [7:0]  dv [3][8];
    logic [19:0] exp_psum  [3];
    bit          exp_valid [3];
    bit          exp_ovf   [3];
    logic [7:0]  exp_data  [3];

    initial begin
        logic [2:0]  slot;
        logic [19:0] r;
        bit          o, hit;
        for (int k = 0; k < 3; k++) begin
            exp_psum[k] = '0; exp_valid[k] = 0; exp_ovf[k] = 0; exp_data[k] = '0;
            for (int s = 0; s < 8; s++) begin
                rv[k][s] = '0; rp[k][s] = 0; ro[k][s] = 0; dv[k][s] = '0;
            end
        end
        forever begin
            @(posedge clk);
            if (sclr) begin
                m_sh = '0;
                m_ac = '0;
                for (int k = 0; k < 3; k++) begin
                    exp_psum[k] = '0; exp_valid[k] = 0; exp_ovf[k] = 0; exp_data[k] = '0;
                    for (int s = 0; s < 8; s++) begin
                        rv[k][s] = '0; rp[k][s] = 0; ro[k][s] = 0; dv[k][s] = '0;
                    end
                end
            end else begin
                if (ce) cnt++;
                for (int k = 0; k < 3; k++) begin
                    hit = 0;
                    if (ce) begin
                        if (valid_in) begin
                            calc(sgn(k), sat(k), data_in, m_ac, psum_in, r, o);
                            slot = 3'(cnt + lat(k) - 1);
                            rv[k][slot] = r;
                            ro[k][slot] = o;
                            rp[k][slot] = 1;
                        end
                        dv[k][3'(cnt + fwd(k) - 1)] = data_in;
                        slot = 3'(cnt);
                        exp_valid[k] = rp[k][slot];
                        if (rp[k][slot]) begin
                            exp_psum[k] = rv[k][slot];
                            hit         = ro[k][slot];
                            rp[k][slot] = 0;
                        end
                        exp_data[k] = dv[k][slot];
                    end
                    if (hit) exp_ovf[k] = 1;
                    else if (ovf_clr) exp_ovf[k] = 0;
                end
                if (w_swap) m_ac = m_sh;
                if (w_load) m_sh = w_in;
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s[pe%0d] @%0t: got %0h, want %0h", nm, k, $time, act, want);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int k = 0; k < 3; k++) begin
                    chk("psum_out", k, 32'(psum_o[k]), 32'(exp_psum[k]));
                    chk("valid_out", k, 32'(valid_o[k]), 32'(exp_valid[k]));
                    chk("ovf", k, 32'(ovf_o[k]), 32'(exp_ovf[k]));
                    chk("data_out", k, 32'(data_o[k]), 32'(exp_data[k]));
                    chk("w_out", k, 32'(wout_o[k]), 32'(m_sh));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        sclr = 0; ce = 1; valid_in = 0; w_load = 0; w_swap = 0; ovf_clr = 0;
    endtask

    // Load+swap a weight, issue one sample, then pin each PE's output at its own latency.
    task automatic pin_sample(input logic [7:0] w, input logic [7:0] d, input logic [19:0] p,
                              input logic [19:0] e0, input logic [19:0] e1,
                              input logic [19:0] e2, input bit o0, input bit o1, input bit o2);
        logic [19:0] e [3];
        bit          o [3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        o[0] = o0; o[1] = o1; o[2] = o2;
        idle();
        w_in = w; w_load = 1; ovf_clr = 1;
        step();
        w_load = 0; ovf_clr = 0; w_swap = 1;
        step();
        w_swap = 0; data_in = d; psum_in = p; valid_in = 1;
        step();
        valid_in = 0;
        for (int t = 1; t <= 3; t++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                if (lat(k) - 1 == t) begin
                    chk("pin_psum", k, 32'(psum_o[k]), 32'(e[k]));
                    chk("pin_valid", k, 32'(valid_o[k]), 32'd1);
                    chk("pin_ovf", k, 32'(ovf_o[k]), 32'(o[k]));
                    chk("pin_model", k, 32'(exp_psum[k]), 32'(e[k]));
                end
            end
        end
    endtask

    logic [19:0] want5 [5];

    initial begin
        idle();
        sclr = 1; data_in = '0; w_in = '0; psum_in = '0;
        step();
        step();
        sclr = 0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_psum", k, 32'(psum_o[k]), 32'd0);
            chk("rst_valid", k, 32'(valid_o[k]), 32'd0);
            chk("rst_ovf", k, 32'(ovf_o[k]), 32'd0);
            chk("rst_wout", k, 32'(wout_o[k]), 32'd0);
        end
        cmp_en = 1;

        // Largest positive product, signed and unsigned overflow, saturation vs wrap.
        pin_sample(8'd127, 8'd127, 20'd0, 20'd16129, 20'd16129, 20'd16129, 0, 0, 0);
        pin_sample(8'h80, 8'h80, 20'hFFFFB, 20'd16379, 20'd16379, 20'hFFFFF, 0, 0, 1);
        pin_sample(8'hFF, 8'hFF, 20'd0, 20'd1, 20'd1, 20'd65025, 0, 0, 0);
        pin_sample(8'd1, 8'd1, 20'h7FFFF, 20'h7FFFF, 20'h80000, 20'h80000, 1, 1, 0);
        idle();
        repeat (3) step();
        chk("ovf_sticky", 0, 32'(ovf_o[0]), 32'd1);
        ovf_clr = 1;
        step();
        ovf_clr = 0;
        chk("ovf_cleared", 0, 32'(ovf_o[0]), 32'd0);

        // Stream with a 3-cycle stall; valid_in held high during the stall must be ignored.
        for (int i = 0; i < 7; i++) begin
            ce = !(i >= 2 && i < 5);
            valid_in = 1;
            data_in = 8'(i * 17 + 3);
            psum_in = 20'(i * 1000);
            step();
        end
        idle();
        repeat (6) step();

        // Active weight 3, shadow reloaded with 5 on sample 1, swapped on sample 3.
        w_in = 8'd3; w_load = 1;
        step();
        w_load = 0; w_swap = 1;
        step();
        w_swap = 0;
        want5[0] = 20'd6; want5[1] = 20'd6; want5[2] = 20'd6; want5[3] = 20'd10; want5[4] = 20'd10;
        for (int i = 0; i < 5; i++) begin
            data_in = 8'd2; psum_in = 20'd0; valid_in = 1;
            w_in = 8'd5; w_load = (i == 0); w_swap = (i == 2);
            step();
            if (i == 0) chk("w_out_load", 0, 32'(wout_o[0]), 32'd5);
            if (i > 0) chk("swap_psum", 0, 32'(psum_o[0]), 32'(want5[i-1]));
        end
        idle();
        step();
        chk("swap_psum", 0, 32'(psum_o[0]), 32'(want5[4]));
        repeat (4) step();

        // Reset with samples in flight, then a fresh sample.
        data_in = 8'd9; psum_in = 20'd1; valid_in = 1;
        step();
        step();
        idle();
        sclr = 1;
        step();
        sclr = 0;
        for (int k = 0; k < 3; k++) begin
            chk("sclr_psum", k, 32'(psum_o[k]), 32'd0);
            chk("sclr_valid", k, 32'(valid_o[k]), 32'd0);
            chk("sclr_data", k, 32'(data_o[k]), 32'd0);
        end
        pin_sample(8'd3, 8'd4, 20'd7, 20'd19, 20'd19, 20'd19, 0, 0, 0);

        // Random traffic biased towards the accumulator range limits.
        for (int n = 0; n < 1500; n++) begin
            sclr     = ($urandom_range(99) < 2);
            ce       = ($urandom_range(3) != 0);
            valid_in = ($urandom_range(9) < 6);
            data_in  = 8'($urandom);
            w_in     = 8'($urandom);
            w_load   = ($urandom_range(4) == 0);
            w_swap   = ($urandom_range(9) == 0);
            ovf_clr  = ($urandom_range(9) == 0);
            case ($urandom_range(3))
                0:       psum_in = 20'h7FF00 + 20'($urandom_range(255));
                1:       psum_in = 20'h80000 + 20'($urandom_range(255));
                2:       psum_in = 20'hFFF00 + 20'($urandom_range(255));
                default: psum_in = 20'($urandom);
            endcase
            step();
        end
        idle();
        repeat (6) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
